// File: rtl/ahb_console_rx.sv
// Host-to-CPU console input: a byte FIFO filled over a valid/ready port and
// drained by Cortex-M0 software through a small AHB-Lite register block.
module ahb_console_rx #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        rx_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Registered address phase
  logic       phase_valid_reg;
  logic [1:0] phase_addr_reg;
  logic       phase_write_reg;

  // FIFO and control state
  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr_reg;
  ptr_t       rd_ptr_reg;
  cnt_t       count_reg;
  cnt_t       count_next;
  logic       overflow_reg;
  logic       irq_en_reg;

  logic       addr_accept;
  logic       dphase_done;
  logic       ctrl_wr;
  logic       flush;
  logic       overflow_clr;
  logic       nonempty;
  logic       full;
  logic       push;
  logic       pop;
  logic [7:0] head_byte;
  logic [7:0] count_byte;
  logic       unused;

  assign nonempty     = (count_reg != '0);
  assign full         = (count_reg == FULL_COUNT);
  assign head_byte    = mem[rd_ptr_reg];
  assign count_byte   = 8'(count_reg);

  assign addr_accept  = HSEL & HREADY & HTRANS[1];
  assign dphase_done  = phase_valid_reg & HREADY;
  assign ctrl_wr      = dphase_done & phase_write_reg & (phase_addr_reg == REG_CTRL);
  assign flush        = ctrl_wr & HWDATA[2];
  assign overflow_clr = ctrl_wr & HWDATA[1];

  // Flush overrides both sides; pop/push gating uses only registered occupancy
  assign pop  = dphase_done & ~phase_write_reg & (phase_addr_reg == REG_DATA)
              & nonempty & ~flush;
  assign push = rx_valid & ~full & ~flush;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      phase_valid_reg <= 1'b0;
      phase_addr_reg  <= 2'd0;
      phase_write_reg <= 1'b0;
    end else if (HREADY) begin
      phase_valid_reg <= addr_accept;
      if (addr_accept) begin
        phase_addr_reg  <= HADDR[3:2];
        phase_write_reg <= HWRITE;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + cnt_t'(1);
        2'b01:   count_next = count_reg - cnt_t'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr_reg] <= rx_data;
  end

  // A new overflow on the same edge as a clear must survive
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      overflow_reg <= 1'b0;
      irq_en_reg   <= 1'b0;
    end else begin
      overflow_reg <= (overflow_reg & ~overflow_clr) | (rx_valid & full);
      if (ctrl_wr) irq_en_reg <= HWDATA[0];
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (phase_valid_reg & ~phase_write_reg) begin
      case (phase_addr_reg)
        REG_DATA: begin
          if (nonempty) HRDATA = {23'h0, 1'b1, head_byte};
        end
        REG_STATUS: begin
          HRDATA[0]    = nonempty;
          HRDATA[1]    = full;
          HRDATA[2]    = overflow_reg;
          HRDATA[15:8] = count_byte;
        end
        REG_CTRL: begin
          HRDATA[0] = irq_en_reg;
        end
        default: HRDATA = 32'h0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign rx_ready  = ~full;
  assign rx_irq    = irq_en_reg & nonempty;

  assign unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:3]};

endmodule

// File: tb/tb_ahb_console_rx.sv
// Scoreboard bench for ahb_console_rx: a queue-based console model predicts
// every read and the rx_ready/rx_irq levels; a monitor checks them.
module tb_ahb_console_rx;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_ready;
  logic        rx_irq;

  ahb_console_rx #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .rx_irq(rx_irq)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd_q[$];
  logic [1:0]  sig_q[$];

  // Reference model: byte queue plus flags, and the pending bus data phase
  byte unsigned m_fifo[$];
  bit          m_ovf = 1'b0;
  bit          m_irq_en = 1'b0;
  bit          m_dp_valid = 1'b0;
  bit          m_dp_write = 1'b0;
  bit [1:0]    m_dp_addr = 2'd0;
  logic [31:0] pend_wdata = 32'h0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  function automatic logic [31:0] model_read(bit [1:0] a);
    logic [31:0] r;
    int n;
    r = 32'h0;
    n = m_fifo.size();
    case (a)
      2'd0: if (n > 0) r = 32'h100 | 32'(m_fifo[0]);
      2'd1: begin
        r[0]    = (n > 0);
        r[1]    = (n == DEPTH);
        r[2]    = m_ovf;
        r[15:8] = 8'(n);
      end
      2'd2: r[0] = m_irq_en;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // One bus cycle: drive inputs, queue expectations, advance the model past the edge
  task automatic drive_cycle(bit rst, bit rdy, bit sel, bit [1:0] trans, logic [31:0] addr,
                             bit wr, logic [31:0] wdata, bit rxv, logic [7:0] rxd);
    bit full, pop, clr, flush;
    HRESET = rst; HREADY = rdy; HSEL = sel; HTRANS = trans; HADDR = addr;
    HWRITE = wr; HWDATA = wdata; rx_valid = rxv; rx_data = rxd;
    HSIZE = 3'($urandom_range(0, 2));
    if (m_dp_valid && !m_dp_write && rdy) rd_q.push_back(model_read(m_dp_addr));
    sig_q.push_back({m_fifo.size() < DEPTH, m_irq_en && (m_fifo.size() > 0)});
    if (rst) begin
      m_fifo.delete();
      m_ovf = 0; m_irq_en = 0; m_dp_valid = 0; m_dp_write = 0; m_dp_addr = 0;
    end else begin
      clr = 0; flush = 0;
      if (m_dp_valid && rdy && m_dp_write && m_dp_addr == 2'd2) begin
        m_irq_en = wdata[0]; clr = wdata[1]; flush = wdata[2];
      end
      full = (m_fifo.size() == DEPTH);
      pop  = m_dp_valid && rdy && !m_dp_write && m_dp_addr == 2'd0 && m_fifo.size() > 0;
      m_ovf = (m_ovf && !clr) || (rxv && full);
      if (flush) m_fifo.delete();
      else begin
        if (pop) void'(m_fifo.pop_front());
        if (rxv && !full) m_fifo.push_back(rxd);
      end
      if (rdy) begin
        m_dp_valid = sel && trans[1];
        if (m_dp_valid) begin
          m_dp_addr = addr[3:2];
          m_dp_write = wr;
        end
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(bit rxv = 1'b0, logic [7:0] rxd = 8'h0);
    drive_cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, pend_wdata, rxv, rxd);
    pend_wdata = 32'h0;
  endtask

  task automatic bus(logic [3:0] off, bit wr, logic [31:0] wdata = 32'h0,
                     bit rxv = 1'b0, logic [7:0] rxd = 8'h0);
    drive_cycle(1'b0, 1'b1, 1'b1, 2'b10, {28'h4000000, off}, wr, pend_wdata, rxv, rxd);
    pend_wdata = wr ? wdata : 32'h0;
  endtask

  // Monitor: tracks read data phases on the bus and compares against the scoreboard
  initial begin : monitor
    bit rd_phase;
    logic [1:0] s;
    rd_phase = 1'b0;
    forever begin
      @(posedge HCLK);
      if (HRESET) rd_phase = 1'b0;
      else if (HREADY) rd_phase = HSEL && HTRANS[1] && !HWRITE;
      @(negedge HCLK);
      if (sig_q.size() > 0) begin
        s = sig_q.pop_front();
        check("rx_ready", 32'(rx_ready), 32'(s[1]));
        check("rx_irq", 32'(rx_irq), 32'(s[0]));
        check("hreadyout", 32'(HREADYOUT), 32'h1);
        check("hresp", 32'(HRESP), 32'h0);
      end
      if (rd_phase && HREADY) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got 0x%08h expected none", HRDATA);
        end else begin
          check("hrdata", HRDATA, rd_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    bit rst, rdy, sel, wr, rxv;
    bit [1:0] tr;
    logic [31:0] a, wd;
    int rx_pct;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    check("hrdata_reset", HRDATA, 32'h0);

    // Reset state
    bus(4'h4, 0); idle();
    // Two bytes in, drained through DATA
    idle(1, 8'h41); idle(1, 8'h42);
    bus(4'h4, 0); bus(4'h0, 0); bus(4'h0, 0); bus(4'h0, 0); bus(4'h4, 0); idle();
    // Overfill, clear overflow, drain in order
    for (int i = 0; i < 17; i++) idle(1, 8'(8'h60 + i));
    bus(4'h4, 0); bus(4'h8, 1, 32'h2); bus(4'h4, 0);
    for (int i = 0; i < 16; i++) bus(4'h0, 0);
    bus(4'h4, 0); idle();
    // Interrupt enable
    bus(4'h8, 1, 32'h1); idle(); idle(1, 8'h55); idle(); bus(4'h0, 0); idle(); idle();
    // Full FIFO with simultaneous push and pop
    bus(4'h8, 1, 32'h6); idle();
    for (int i = 0; i < 16; i++) idle(1, 8'(8'hA0 + i));
    bus(4'h0, 0); idle(1, 8'hEE); bus(4'h4, 0); idle();
    // Flush racing a push
    bus(4'h8, 1, 32'h6); idle();
    for (int i = 0; i < 5; i++) idle(1, 8'(8'hC0 + i));
    bus(4'h8, 1, 32'h4); idle(1, 8'h77); bus(4'h4, 0); bus(4'h0, 0); idle();
    // Reset in the middle of a read burst
    bus(4'h8, 1, 32'h1); idle(1, 8'h11); idle(1, 8'h12); idle(1, 8'h13);
    bus(4'h0, 0); bus(4'h0, 0);
    drive_cycle(1, 1, 1, 2'b10, 32'h0, 0, 32'h0, 1, 8'h14);
    drive_cycle(1, 1, 0, 2'b00, 32'h0, 0, 32'h0, 0, 8'h0);
    pend_wdata = 32'h0;
    check("hrdata_after_rst", HRDATA, 32'h0);
    bus(4'h4, 0); bus(4'h8, 0); bus(4'h0, 0); idle();

    // Randomized traffic with bus stalls, resets and varying host rate
    rx_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) rx_pct = $urandom_range(10, 90);
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      sel = ($urandom_range(0, 3) != 0);
      tr  = 2'($urandom);
      wr  = ($urandom_range(0, 3) == 0);
      a   = $urandom;
      wd  = $urandom;
      wd[2] = ($urandom_range(0, 15) == 0);
      rxv = ($urandom_range(0, 99) < rx_pct);
      drive_cycle(rst, rdy, sel, tr, a, wr, wd, rxv, 8'($urandom));
    end
    drive_cycle(0, 1, 0, 2'b00, 32'h0, 0, 32'h0, 0, 8'h0);
    repeat (3) idle();
    check("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
